cache_fill_fsm: RTL and testbench

- Miss-handling controller for one cache (I- or D-side) in the pipelined core.
- On a miss, reads the full 16-byte block (8 x 16-bit words) from the multi-cycle pipelined main memory.
- Produces, per returned word, a write strobe and a 3-bit word index. The downstream word-enable decoder turns the index into the one-hot data-array word select.
- Asserts busy so the pipeline stalls until the block and its tag are written.

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_fill_fsm_if.sv | 30 +++
 rtl/cache_fill_fsm.sv | 75 +++++++
 tb/tb_cache_fill_fsm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache miss-fill controller.
// Imported by the fill FSM and its bus interface.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int WORDS_PER_BLK = 8;
    localparam int BLK_OFFSET_W  = 4;
    localparam int WORD_BYTES    = 2;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/array-write bundle between the fill controller and the
// cache, main memory and data/tag array write ports.
interface cache_fill_fsm_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = $clog2(WORDS_PER_BLK)
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [IDX_W-1:0]  word_idx;
    logic              write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, mem_read_en, memory_address,
        output write_data_array, word_idx, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, mem_read_en, memory_address,
        input  write_data_array, word_idx, write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: streams one block of words from pipelined
// memory into the data array, then writes the tag alongside the last word.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = $clog2(WORDS_PER_BLK)
) (
    input  logic clk,
    input  logic rst_n,
    cache_fill_fsm_if.master bus
);
    localparam int WSH   = $clog2(WORD_BYTES);
    localparam int OFF_W = IDX_W + WSH;
    localparam logic [IDX_W:0]   ISSUE_MAX = (IDX_W+1)'(2**IDX_W);
    localparam logic [IDX_W-1:0] RECV_LAST = '1;

    state_t            state;
    logic [IDX_W:0]    issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic [ADDR_W-1:0] base_addr;

    logic in_fill;
    logic issue;
    logic recv;
    logic last;

    // Request/return strobes derived from state, counters and memory valid.
    always_comb begin
        in_fill = (state == FILL);
        issue   = in_fill && (issue_cnt < ISSUE_MAX);
        recv    = in_fill && bus.memory_data_valid;
        last    = recv && (recv_cnt == RECV_LAST);

        bus.fsm_busy         = in_fill;
        bus.mem_read_en      = issue;
        bus.write_data_array = recv;
        bus.write_tag_array  = last;
        bus.word_idx         = in_fill ? recv_cnt : '0;
        bus.memory_address   = '0;
        if (in_fill) begin
            bus.memory_address = base_addr |
                (ADDR_W'(issue_cnt[IDX_W-1:0]) << WSH);
        end
    end

    // State, block base and the independent issue/receive counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base_addr <= {bus.miss_address[ADDR_W-1:OFF_W],
                                      OFF_W'(0)};
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (issue) issue_cnt <= issue_cnt + 1'b1;
                    if (recv)  recv_cnt  <= recv_cnt + 1'b1;
                    if (last)  state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: reset, basic and gapped fills,
// ignored mid-fill miss, reset abort and back-to-back misses.
module tb_cache_fill_fsm;
    localparam int AW = 16;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cache_fill_fsm_if #(.ADDR_W(AW), .IDX_W(IW)) bus ();

    cache_fill_fsm #(.ADDR_W(AW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          rd;
        logic          wr;
        logic          tag;
        logic [AW-1:0] addr;
        logic [IW-1:0] idx;
    } obs_t;

    obs_t obs [64];
    int n_cmp = 0;
    int n_bad = 0;

    // Drive one input set per cycle at negedge, sample outputs 1 unit later.
    task automatic drive(input int n, input logic [63:0] vm,
                         input logic [63:0] mm, input logic [63:0] rm,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input int sw);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.memory_data_valid = vm[c];
            bus.miss_detected     = mm[c];
            bus.miss_address      = (c < sw) ? a0 : a1;
            rst_n                 = ~rm[c];
            #1;
            obs[c].busy = bus.fsm_busy;
            obs[c].rd   = bus.mem_read_en;
            obs[c].wr   = bus.write_data_array;
            obs[c].tag  = bus.write_tag_array;
            obs[c].addr = bus.memory_address;
            obs[c].idx  = bus.word_idx;
        end
        @(negedge clk);
        bus.memory_data_valid = 1'b0;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        rst_n                 = 1'b1;
    endtask

    // Expected outputs in cycle c of a fill whose first FILL cycle is s.
    function automatic obs_t fill_exp(input int c, input int s,
                                      input logic [AW-1:0] base,
                                      input logic [63:0] vm);
        obs_t e;
        int k;
        int last;
        int cnt;
        e = '0;
        k = 0;
        last = 63;
        cnt = 0;
        for (int i = s; i < 64; i++) begin
            if (vm[i]) begin
                cnt++;
                if (cnt == 8) begin
                    last = i;
                    break;
                end
            end
        end
        for (int i = s; i < c; i++) if (vm[i]) k++;
        if (c >= s && c <= last) begin
            e.busy = 1'b1;
            e.rd   = (c < s + 8);
            e.addr = e.rd ? base + AW'(2 * (c - s)) : base;
            e.wr   = vm[c];
            e.idx  = IW'(k);
            e.tag  = vm[c] && (k == 7);
        end
        return e;
    endfunction

    task automatic test_reset();
        logic [63:0] vm;
        vm = '1;
        drive(6, vm, 64'h0, 64'h3, 16'h0000, 16'h0000, 0);
        for (int c = 1; c < 6; c++) begin
            n_cmp++;
            if (obs[c] !== obs_t'(0)) begin
                n_bad++;
                $display("FAIL reset c%0d got %h exp 0", c, obs[c]);
            end
        end
    endtask

    task automatic test_basic();
        logic [63:0] vm;
        obs_t e;
        vm = '0;
        for (int i = 5; i <= 12; i++) vm[i] = 1'b1;
        drive(14, vm, 64'h1, 64'h0, 16'h1236, 16'h1236, 0);
        for (int c = 0; c < 14; c++) begin
            e = fill_exp(c, 1, 16'h1230, vm);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL basic c%0d got %h exp %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_gapped();
        logic [63:0] vm;
        obs_t e;
        vm = '0;
        vm[3] = 1'b1;  vm[7] = 1'b1;  vm[8] = 1'b1;  vm[14] = 1'b1;
        vm[17] = 1'b1; vm[18] = 1'b1; vm[20] = 1'b1; vm[25] = 1'b1;
        drive(27, vm, 64'h1, 64'h0, 16'hFFFE, 16'hFFFE, 0);
        for (int c = 0; c < 27; c++) begin
            e = fill_exp(c, 1, 16'hFFF0, vm);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL gapped c%0d got %h exp %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_miss_busy();
        logic [63:0] vm;
        logic [63:0] mm;
        obs_t e;
        int reqs;
        vm = '0;
        for (int i = 5; i <= 12; i++) vm[i] = 1'b1;
        mm = 64'h1;
        mm[3] = 1'b1;
        drive(14, vm, mm, 64'h0, 16'h1230, 16'h4000, 1);
        reqs = 0;
        for (int c = 0; c < 14; c++) begin
            if (obs[c].rd) reqs++;
            e = fill_exp(c, 1, 16'h1230, vm);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL missbusy c%0d got %h exp %h", c, obs[c], e);
            end
        end
        n_cmp++;
        if (reqs !== 8) begin
            n_bad++;
            $display("FAIL missbusy_reqs got %0d exp 8", reqs);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] vm;
        logic [63:0] rm;
        obs_t e;
        vm = '0;
        for (int i = 5; i <= 12; i++) vm[i] = 1'b1;
        rm = '0;
        rm[8] = 1'b1;
        drive(14, vm, 64'h1, rm, 16'h1230, 16'h1230, 0);
        for (int c = 0; c < 14; c++) begin
            e = (c <= 8) ? fill_exp(c, 1, 16'h1230, vm) : obs_t'(0);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL rstmid c%0d got %h exp %h", c, obs[c], e);
            end
        end
        vm = '0;
        for (int i = 3; i <= 10; i++) vm[i] = 1'b1;
        drive(12, vm, 64'h1, 64'h0, 16'h0020, 16'h0020, 0);
        for (int c = 0; c < 12; c++) begin
            e = fill_exp(c, 1, 16'h0020, vm);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL rstrefill c%0d got %h exp %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vm;
        logic [63:0] mm;
        obs_t e;
        vm = '0;
        for (int i = 5; i <= 12; i++) vm[i] = 1'b1;
        for (int i = 18; i <= 25; i++) vm[i] = 1'b1;
        mm = '0;
        for (int i = 0; i <= 13; i++) mm[i] = 1'b1;
        drive(27, vm, mm, 64'h0, 16'h2000, 16'h3008, 1);
        for (int c = 0; c < 27; c++) begin
            e = (c <= 13) ? fill_exp(c, 1, 16'h2000, vm)
                          : fill_exp(c, 14, 16'h3000, vm);
            n_cmp++;
            if (obs[c] !== e) begin
                n_bad++;
                $display("FAIL b2b c%0d got %h exp %h", c, obs[c], e);
            end
        end
    endtask

    initial begin
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data_valid = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_miss_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
